// File: rtl/svsg_pkg.sv
// Shared constants and types for the seven-segment scan controller:
// register map, scan states and segment codes ({a,b,c,d,e,f,g,dp}).
package svsg_pkg;

  localparam logic [31:0] BASE         = 32'h3000_0000;
  localparam logic [15:0] PRESCALE_RST = 16'd999;

  localparam logic [1:0] OFF_DIGITS   = 2'd0;
  localparam logic [1:0] OFF_CTRL     = 2'd1;
  localparam logic [1:0] OFF_PRESCALE = 2'd2;
  localparam logic [1:0] OFF_STATUS   = 2'd3;

  // BLANK lasts two cycles: cnt counts 0 then 1.
  localparam logic [15:0] BLANK_LAST = 16'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  localparam logic [7:0] SEG_0     = 8'b1111_1100;
  localparam logic [7:0] SEG_1     = 8'b0110_0000;
  localparam logic [7:0] SEG_2     = 8'b1101_1010;
  localparam logic [7:0] SEG_3     = 8'b1111_0010;
  localparam logic [7:0] SEG_4     = 8'b0110_0110;
  localparam logic [7:0] SEG_5     = 8'b1011_0110;
  localparam logic [7:0] SEG_6     = 8'b1011_1110;
  localparam logic [7:0] SEG_7     = 8'b1110_0000;
  localparam logic [7:0] SEG_8     = 8'b1111_1110;
  localparam logic [7:0] SEG_9     = 8'b1111_0110;
  localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

endpackage

// File: rtl/svsg_scan_ctrl_if.sv
// Wishbone slave bundle for the scan controller; the controller takes the
// slave view, a bus master (or bench) takes the master view.
interface svsg_scan_ctrl_if;

  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/svsg_decode.sv
// Combinational BCD to seven-segment decoder; codes 10-15 show blank.
module svsg_decode
  import svsg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/svsg_scan_ctrl.sv
// Wishbone-configured scan controller: multiplexes four BCD digits onto one
// shared segment bus with one-hot digit enables and an optional blanking gap.
module svsg_scan_ctrl
  import svsg_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  svsg_scan_ctrl_if.slave         wb,
  output logic [7:0]              svsg,
  output logic [3:0]              dig_en,
  output logic [11:0]             io_oeb
);

  logic        hit;
  logic        acc;
  logic [1:0]  off;
  logic [31:0] rd_data;

  logic [15:0] digits_q, digits_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [15:0] prescale_q, prescale_d;
  logic        ack_q;
  logic [31:0] dat_q;

  scan_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  svsg_q, svsg_d;
  logic [3:0]  dig_en_q, dig_en_d;

  logic [7:0]  seg_codes [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      svsg_decode u_dec (
        .bcd_i (digits_q[4*gi +: 4]),
        .seg_o (seg_codes[gi])
      );
    end
  endgenerate

  // Address bits below the word offset and the upper data/lane bits carry no registers.
  logic unused_bits;
  assign unused_bits = &{1'b0, wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:16], wb.wbs_sel_i[3:2]};

  always_comb begin
    off  = wb.wbs_adr_i[3:2];
    hit  = wb.wbs_cyc_i && wb.wbs_stb_i && (wb.wbs_adr_i[31:4] == BASE[31:4]);
    acc  = hit && !ack_q;

    rd_data = '0;
    case (off)
      OFF_DIGITS:   rd_data[15:0] = digits_q;
      OFF_CTRL:     rd_data[1:0]  = ctrl_q;
      OFF_PRESCALE: rd_data[15:0] = prescale_q;
      default:      rd_data[2:0]  = {state_q != IDLE, idx_q};
    endcase

    digits_d   = digits_q;
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    if (acc && wb.wbs_we_i) begin
      case (off)
        OFF_DIGITS: begin
          for (int b = 0; b < 2; b++) begin
            if (wb.wbs_sel_i[b]) digits_d[8*b +: 8] = wb.wbs_dat_i[8*b +: 8];
          end
        end
        OFF_CTRL: begin
          if (wb.wbs_sel_i[0]) ctrl_d = wb.wbs_dat_i[1:0];
        end
        OFF_PRESCALE: begin
          for (int b = 0; b < 2; b++) begin
            if (wb.wbs_sel_i[b]) prescale_d[8*b +: 8] = wb.wbs_dat_i[8*b +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  // Read data is captured from the pre-update register values on the ack edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      digits_q   <= '0;
      ctrl_q     <= '0;
      prescale_q <= PRESCALE_RST;
    end else begin
      ack_q      <= acc;
      if (acc) dat_q <= rd_data;
      digits_q   <= digits_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!ctrl_q[0]) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DRIVE;
          cnt_d   = '0;
          idx_d   = '0;
        end
        DRIVE: begin
          // >= so a PRESCALE lowered below the running count ends the digit at once.
          if (cnt_q >= prescale_q) begin
            cnt_d = '0;
            if (ctrl_q[1]) state_d = BLANK;
            else           idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        BLANK: begin
          if (cnt_q >= BLANK_LAST) begin
            cnt_d   = '0;
            state_d = DRIVE;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Pad outputs follow the next state so they line up with the state register.
  always_comb begin
    svsg_d   = SEG_BLANK;
    dig_en_d = 4'b0000;
    if (state_d == DRIVE) begin
      svsg_d   = seg_codes[idx_d];
      dig_en_d = 4'b0001 << idx_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      svsg_q   <= SEG_BLANK;
      dig_en_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      svsg_q   <= svsg_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign svsg   = svsg_q;
  assign dig_en = dig_en_q;
  assign io_oeb = 12'd0;

endmodule

// File: tb/tb_svsg_scan_ctrl.sv
// Directed bench for svsg_scan_ctrl: register access, scan sequencing,
// blanking, disable, bus corner cases and asynchronous reset.
module tb_svsg_scan_ctrl;

  localparam logic [31:0] TB_BASE = 32'h3000_0000;

  logic        clk;
  logic        reset;
  logic [7:0]  svsg;
  logic [3:0]  dig_en;
  logic [11:0] io_oeb;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                               8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  svsg_scan_ctrl_if wb_if ();

  svsg_scan_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .wb     (wb_if),
    .svsg   (svsg),
    .dig_en (dig_en),
    .io_oeb (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata, output logic acked);
    wb_if.wbs_cyc_i = 1'b1;
    wb_if.wbs_stb_i = 1'b1;
    wb_if.wbs_we_i  = we;
    wb_if.wbs_adr_i = adr;
    wb_if.wbs_dat_i = dat;
    wb_if.wbs_sel_i = sel;
    acked = 1'b0;
    rdata = '0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk); #1;
      if (wb_if.wbs_ack_o) begin
        acked = 1'b1;
        rdata = wb_if.wbs_dat_o;
      end
    end
    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_stb_i = 1'b0;
    wb_if.wbs_we_i  = 1'b0;
    $display("wb %s adr=0x%08h dat=0x%08h sel=%b ack=%0b rdata=0x%08h",
             we ? "wr" : "rd", adr, dat, sel, acked, rdata);
  endtask

  task automatic wb_write(input logic [1:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    logic ok;
    wb_xfer(1'b1, TB_BASE + {28'd0, off, 2'b00}, dat, sel, rd, ok);
    check($sformatf("ack_wr%0d", off), {31'd0, ok}, 32'd1);
  endtask

  task automatic wb_read(input logic [1:0] off, output logic [31:0] data);
    logic ok;
    wb_xfer(1'b0, TB_BASE + {28'd0, off, 2'b00}, 32'd0, 4'hF, data, ok);
    check($sformatf("ack_rd%0d", off), {31'd0, ok}, 32'd1);
  endtask

  // Sample n cycles starting one edge after the enabling ack edge.
  task automatic scan_check(input logic [15:0] digs, input int pre, input bit blank,
                            input int n, input string tag);
    int period, ph, d;
    logic [3:0] en_exp;
    logic [7:0] seg_exp;
    period = pre + 1 + (blank ? 2 : 0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      ph = k % period;
      d  = (k / period) % 4;
      if (ph <= pre) begin
        en_exp  = 4'b0001 << d;
        seg_exp = seg_tab[digs[4*d +: 4]];
      end else begin
        en_exp  = 4'b0000;
        seg_exp = 8'h00;
      end
      check($sformatf("%s_en%0d", tag, k), {28'd0, dig_en}, {28'd0, en_exp});
      check($sformatf("%s_seg%0d", tag, k), {24'd0, svsg}, {24'd0, seg_exp});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic ok;
    bit found;

    reset = 1'b0;
    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_stb_i = 1'b0;
    wb_if.wbs_we_i  = 1'b0;
    wb_if.wbs_sel_i = 4'h0;
    wb_if.wbs_dat_i = 32'd0;
    wb_if.wbs_adr_i = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_svsg", {24'd0, svsg}, 32'd0);
    check("rst_dig_en", {28'd0, dig_en}, 32'd0);
    check("rst_ack", {31'd0, wb_if.wbs_ack_o}, 32'd0);
    check("rst_dat", wb_if.wbs_dat_o, 32'd0);
    check("rst_oeb", {20'd0, io_oeb}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    wb_read(2'd2, rd);
    check("rst_prescale", rd, 32'd999);
    wb_read(2'd3, rd);
    check("rst_status", rd, 32'd0);

    // Scan without blanking
    wb_write(2'd0, 32'h0000_4321, 4'hF);
    wb_write(2'd2, 32'd2, 4'hF);
    wb_write(2'd1, 32'd1, 4'hF);
    scan_check(16'h4321, 2, 1'b0, 14, "scan");
    wb_read(2'd3, rd);
    check("status_scanning", {31'd0, rd[2]}, 32'd1);
    check("status_upper", {3'd0, rd[31:3]}, 32'd0);

    // Blanking, started cleanly from IDLE
    wb_write(2'd1, 32'd0, 4'hF);
    wb_write(2'd1, 32'd3, 4'hF);
    scan_check(16'h4321, 2, 1'b1, 22, "blank");
    wb_read(2'd1, rd);
    check("ctrl_rb", rd, 32'd3);

    // Disable during digit 2
    wb_write(2'd1, 32'd1, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (dig_en == 4'b0100) found = 1'b1;
    end
    check("wait_dig2", {31'd0, found}, 32'd1);
    wb_write(2'd1, 32'd0, 4'hF);
    @(posedge clk); #1;
    check("dis_dig_en", {28'd0, dig_en}, 32'd0);
    check("dis_svsg", {24'd0, svsg}, 32'd0);
    wb_read(2'd3, rd);
    check("dis_status", rd, 32'd0);

    // Invalid codes blank digits 0 and 1
    wb_write(2'd0, 32'h0000_00AF, 4'hF);
    wb_write(2'd1, 32'd1, 4'hF);
    scan_check(16'h00AF, 2, 1'b0, 7, "inv");

    // Byte-lane write touches only DIGITS[15:8]
    wb_write(2'd0, 32'h0000_7700, 4'b0010);
    wb_read(2'd0, rd);
    check("byte_lane", rd, 32'h0000_77AF);

    // PRESCALE lowered below the running count
    wb_write(2'd1, 32'd0, 4'hF);
    wb_write(2'd2, 32'd10, 4'hF);
    wb_write(2'd1, 32'd1, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    check("ps_hold", {28'd0, dig_en}, 32'd1);
    wb_write(2'd2, 32'd2, 4'hF);
    check("ps_ack_edge", {28'd0, dig_en}, 32'd1);
    @(posedge clk); #1;
    check("ps_shrink", {28'd0, dig_en}, 32'd2);

    // Outside the window: never acked
    wb_xfer(1'b0, TB_BASE + 32'h10, 32'd0, 4'hF, rd, ok);
    check("miss_noack", {31'd0, ok}, 32'd0);

    // Back-to-back strobe: ack every other cycle
    wb_if.wbs_cyc_i = 1'b1;
    wb_if.wbs_stb_i = 1'b1;
    wb_if.wbs_we_i  = 1'b0;
    wb_if.wbs_adr_i = TB_BASE;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_ack%0d", k), {31'd0, wb_if.wbs_ack_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_stb_i = 1'b0;
    $display("wb b2b rd adr=0x%08h cycles=6", TB_BASE);

    // Async reset mid-DRIVE, between clock edges
    @(posedge clk); #1;
    check("arst_pre_scan", {31'd0, dig_en != 4'b0000}, 32'd1);
    #3 reset = 1'b0;
    #1;
    check("arst_dig_en", {28'd0, dig_en}, 32'd0);
    check("arst_svsg", {24'd0, svsg}, 32'd0);
    #3 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_stays_idle", {28'd0, dig_en}, 32'd0);
    wb_read(2'd2, rd);
    check("arst_prescale", rd, 32'd999);
    wb_read(2'd0, rd);
    check("arst_digits", rd, 32'd0);
    wb_write(2'd1, 32'd1, 4'hF);
    @(posedge clk); #1;
    check("arst_restart_en", {28'd0, dig_en}, 32'd1);
    check("arst_restart_seg", {24'd0, svsg}, 32'h0000_00FC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
